// File: rtl/gpu_sdram_pkg.sv
// rtl/gpu_sdram_pkg.sv - shared SDRAM command encodings, init states and timing defaults
package gpu_sdram_pkg;

    // {RAS_n, CAS_n, WE_n}
    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_MRS = 3'b000;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_WR  = 3'b100;

    localparam int INIT_WAIT_DEF   = 7200;
    localparam int LINE_ROUNDS_DEF = 288;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_PRE,
        ST_REF,
        ST_MRS,
        ST_RUN
    } init_state_t;

endpackage

// File: rtl/gpu_sdram_sched_if.sv
// rtl/gpu_sdram_sched_if.sv - slot-grid and init-command bundle shared by SDRAM clients
interface gpu_sdram_sched_if;
    logic        line_start;
    logic        init_done;
    logic        init_vld;
    logic [2:0]  init_cmd;
    logic [12:0] init_addr;
    logic [3:0]  ram_ph;
    logic [3:0]  ram_cyc;
    logic [8:0]  ram_ph_ctr;
    logic        ram_ref;

    modport master (
        input  line_start,
        output init_done, init_vld, init_cmd, init_addr,
        output ram_ph, ram_cyc, ram_ph_ctr, ram_ref
    );

    modport slave (
        output line_start,
        input  init_done, init_vld, init_cmd, init_addr,
        input  ram_ph, ram_cyc, ram_ph_ctr, ram_ref
    );
endinterface

// File: rtl/gpu_sdram_init.sv
// rtl/gpu_sdram_init.sv - SDRAM power-up FSM: wait, precharge-all, auto-refreshes, mode load
module gpu_sdram_init
    import gpu_sdram_pkg::*;
#(
    parameter int          INIT_WAIT = INIT_WAIT_DEF,
    parameter int          INIT_REFS = 8,
    parameter logic [12:0] MODE_REG  = 13'h0022
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        round_end,
    output logic        init_done,
    output logic        init_vld,
    output logic [2:0]  init_cmd,
    output logic [12:0] init_addr
);

    generate
        if (INIT_WAIT < 1 || INIT_WAIT > 8191 || INIT_REFS < 1 || INIT_REFS > 255) begin : g_bad_cfg
            $error("gpu_sdram_init: INIT_WAIT or INIT_REFS out of range");
        end
    endgenerate

    init_state_t state;
    logic [12:0] wait_cnt;
    logic [7:0]  ref_cnt;

    // Commands are launched on the round-end edge so they appear on ram_cyc[0]&ram_ph[0].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_WAIT;
            wait_cnt  <= '0;
            ref_cnt   <= '0;
            init_done <= 1'b0;
            init_vld  <= 1'b0;
            init_cmd  <= CMD_NOP;
            init_addr <= '0;
        end else begin
            init_vld  <= 1'b0;
            init_cmd  <= CMD_NOP;
            init_addr <= '0;
            case (state)
                ST_WAIT: begin
                    if (wait_cnt != 13'(INIT_WAIT)) begin
                        wait_cnt <= wait_cnt + 13'd1;
                    end else if (round_end) begin
                        state     <= ST_PRE;
                        init_vld  <= 1'b1;
                        init_cmd  <= CMD_PRE;
                        init_addr <= 13'h0400;
                    end
                end
                ST_PRE: state <= ST_REF;
                ST_REF: begin
                    if (round_end) begin
                        init_vld <= 1'b1;
                        init_cmd <= CMD_REF;
                        ref_cnt  <= ref_cnt + 8'd1;
                        if (ref_cnt == 8'(INIT_REFS - 1)) state <= ST_MRS;
                    end
                end
                ST_MRS: begin
                    if (round_end) begin
                        state     <= ST_RUN;
                        init_vld  <= 1'b1;
                        init_cmd  <= CMD_MRS;
                        init_addr <= MODE_REG;
                    end
                end
                ST_RUN:  init_done <= 1'b1;
                default: state <= ST_WAIT;
            endcase
        end
    end

endmodule

// File: rtl/gpu_sdram_sched.sv
// rtl/gpu_sdram_sched.sv - SDRAM slot-grid scheduler: phase/bank strobes, line round counter, refresh window
module gpu_sdram_sched
    import gpu_sdram_pkg::*;
#(
    parameter int          INIT_WAIT   = INIT_WAIT_DEF,
    parameter int          INIT_REFS   = 8,
    parameter int          LINE_ROUNDS = LINE_ROUNDS_DEF,
    parameter int          REF_START   = 256,
    parameter int          REF_ROUNDS  = 8,
    parameter logic [12:0] MODE_REG    = 13'h0022
) (
    input  logic              clk,
    input  logic              rst,
    gpu_sdram_sched_if.master bus
);

    generate
        if (LINE_ROUNDS < 1 || LINE_ROUNDS > 512 || REF_START + REF_ROUNDS > LINE_ROUNDS) begin : g_bad_cfg
            $error("gpu_sdram_sched: LINE_ROUNDS / refresh window out of range");
        end
    endgenerate

    logic [3:0] ph;
    logic [3:0] cyc;
    logic [8:0] ctr;
    logic [8:0] ctr_nxt;
    logic       pend;
    logic       ref_q;
    logic       done;
    logic       round_end;
    logic       in_window;

    assign round_end = cyc[3] & ph[3];

    gpu_sdram_init #(
        .INIT_WAIT (INIT_WAIT),
        .INIT_REFS (INIT_REFS),
        .MODE_REG  (MODE_REG)
    ) u_init (
        .clk       (clk),
        .rst       (rst),
        .round_end (round_end),
        .init_done (done),
        .init_vld  (bus.init_vld),
        .init_cmd  (bus.init_cmd),
        .init_addr (bus.init_addr)
    );

    // A line_start arriving on the round-end clock itself is honoured by that round end.
    always_comb begin
        ctr_nxt = ctr;
        if (done && round_end) begin
            if (pend || bus.line_start)            ctr_nxt = '0;
            else if (ctr == 9'(LINE_ROUNDS - 1))   ctr_nxt = '0;
            else                                   ctr_nxt = ctr + 9'd1;
        end
    end

    assign in_window = (ctr_nxt >= 9'(REF_START)) &&
                       ({1'b0, ctr_nxt} < 10'(REF_START + REF_ROUNDS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph    <= 4'b0001;
            cyc   <= 4'b0001;
            ctr   <= '0;
            pend  <= 1'b0;
            ref_q <= 1'b0;
        end else begin
            ph    <= {ph[2:0], ph[3]};
            if (ph[3]) cyc <= {cyc[2:0], cyc[3]};
            ctr   <= ctr_nxt;
            ref_q <= done & in_window;
            if (!done || round_end) pend <= 1'b0;
            else if (bus.line_start) pend <= 1'b1;
        end
    end

    assign bus.ram_ph     = ph;
    assign bus.ram_cyc    = cyc;
    assign bus.ram_ph_ctr = ctr;
    assign bus.ram_ref    = ref_q;
    assign bus.init_done  = done;

endmodule

// File: tb/tb_gpu_sdram_sched.sv
// tb/tb_gpu_sdram_sched.sv - self-checking bench for gpu_sdram_sched
module tb_gpu_sdram_sched;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    gpu_sdram_sched_if bus ();

    gpu_sdram_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [12:0] addr;
    } cmd_t;

    cmd_t       exp_q[$];
    logic [3:0] m_ph, m_cyc;
    int         m_ctr;
    logic       m_pend, m_ref, m_done, mrs_seen;
    int         cyc_n, last_cmd, refs_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 4'b0001; m_cyc = 4'b0001; m_ctr = 0;
        m_pend = 0; m_ref = 0; m_done = 0; mrs_seen = 0;
        cyc_n = 0; last_cmd = -1; refs_seen = 0;
        exp_q.delete();
        exp_q.push_back({3'b010, 13'h0400});
        for (int i = 0; i < 8; i++) exp_q.push_back({3'b001, 13'h0000});
        exp_q.push_back({3'b000, 13'h0022});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ph"},   32'(bus.ram_ph), 32'h1);
        chk({tag, "_cyc"},  32'(bus.ram_cyc), 32'h1);
        chk({tag, "_ctr"},  32'(bus.ram_ph_ctr), 32'h0);
        chk({tag, "_ref"},  32'(bus.ram_ref), 32'h0);
        chk({tag, "_done"}, 32'(bus.init_done), 32'h0);
        chk({tag, "_vld"},  32'(bus.init_vld), 32'h0);
        chk({tag, "_cmd"},  32'(bus.init_cmd), 32'h7);
        chk({tag, "_addr"}, 32'(bus.init_addr), 32'h0);
    endtask

    // One clock: advance the reference model on the posedge, compare on the negedge.
    task automatic tick();
        logic ls, re;
        cmd_t e;
        ls = bus.line_start;
        @(posedge clk);
        re = m_cyc[3] & m_ph[3];
        if (m_done) begin
            if (re) begin
                if (m_pend || ls)     m_ctr = 0;
                else if (m_ctr == 287) m_ctr = 0;
                else                   m_ctr = m_ctr + 1;
                m_pend = 0;
            end else if (ls) m_pend = 1;
        end else m_pend = 0;
        m_ref = m_done && m_ctr >= 256 && m_ctr < 264;
        m_done = m_done | mrs_seen;
        if (m_ph[3]) m_cyc = {m_cyc[2:0], m_cyc[3]};
        m_ph = {m_ph[2:0], m_ph[3]};
        @(negedge clk);
        cyc_n++;
        chk("ph", 32'(bus.ram_ph), 32'(m_ph));
        chk("cyc", 32'(bus.ram_cyc), 32'(m_cyc));
        chk("ph_ctr", 32'(bus.ram_ph_ctr), 32'(m_ctr));
        chk("ref", 32'(bus.ram_ref), 32'(m_ref));
        chk("init_done", 32'(bus.init_done), 32'(m_done));
        if (bus.init_vld === 1'b1) begin
            chk("cmd_align", {24'h0, bus.ram_cyc, bus.ram_ph}, 32'h11);
            chk("cmd_expected", 32'(exp_q.size() != 0), 32'h1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("init_cmd", 32'(bus.init_cmd), 32'(e.cmd));
                chk("init_addr", 32'(bus.init_addr), 32'(e.addr));
                if (e.cmd == 3'b010)
                    chk("pre_time", 32'(cyc_n >= 7200 && cyc_n <= 7216), 32'h1);
                else
                    chk("cmd_spacing", 32'(cyc_n - last_cmd), 32'd16);
                if (e.cmd == 3'b001) refs_seen++;
                if (e.cmd == 3'b000) mrs_seen = 1;
            end
            last_cmd = cyc_n;
        end
    endtask

    task automatic run_init(input int budget);
        int n = 0;
        while (!m_done && n < budget) begin
            tick();
            n++;
        end
        chk("init_finished", 32'(m_done), 32'h1);
        chk("init_queue_empty", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        int n, ref_clks;
        logic wrapped;
        bus.line_start = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b1;

        // line_start during init is ignored
        repeat (100) tick();
        bus.line_start = 1'b1;
        tick();
        bus.line_start = 1'b0;
        run_init(7600);

        n = 0;
        while (!(m_ph == 4'b0001 && m_cyc == 4'b0001) && n < 32) begin tick(); n++; end
        chk("first_round_count", 32'(bus.ram_ph_ctr), 32'd1);

        ref_clks = 0;
        wrapped = 1'b0;
        for (int i = 0; i < 288 * 16; i++) begin
            n = m_ctr;
            tick();
            if (bus.ram_ref === 1'b1) ref_clks++;
            if (n == 287 && m_ctr == 0 && bus.ram_ph_ctr === 9'd0) wrapped = 1'b1;
        end
        chk("ref_clocks_per_line", 32'(ref_clks), 32'd128);
        chk("line_wrap_seen", 32'(wrapped), 32'h1);

        // resync mid-round
        n = 0;
        while (!(m_ctr == 100 && m_ph == 4'b0010) && n < 6000) begin tick(); n++; end
        chk("reach_ctr_100", 32'(bus.ram_ph_ctr), 32'd100);
        bus.line_start = 1'b1;
        tick();
        bus.line_start = 1'b0;
        n = 0;
        while (!(m_ph == 4'b0001 && m_cyc == 4'b0001) && n < 32) begin tick(); n++; end
        chk("resync_mid_round", 32'(bus.ram_ph_ctr), 32'd0);

        // resync coincident with round end
        repeat (40) tick();
        n = 0;
        while (!(m_ph == 4'b1000 && m_cyc == 4'b1000) && n < 32) begin tick(); n++; end
        bus.line_start = 1'b1;
        tick();
        bus.line_start = 1'b0;
        chk("resync_coincident", 32'(bus.ram_ph_ctr), 32'd0);
        repeat (16) tick();
        chk("after_coincident", 32'(bus.ram_ph_ctr), 32'd1);

        // asynchronous reset during the refresh phase, then a full rerun
        rst = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rst = 1'b1;
        n = 0;
        while (refs_seen < 3 && n < 7600) begin tick(); n++; end
        chk("three_refs_before_reset", 32'(refs_seen), 32'd3);
        #3 rst = 1'b0;
        #1 chk_reset("mid_reset");
        @(negedge clk);
        model_reset();
        rst = 1'b1;
        run_init(7600);
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpu_sdram_sched.md
# gpu_sdram_sched

SDRAM time-slot scheduler for the 1943 GPU, running on the 72 MHz master clock. After reset it runs the SDRAM power-up sequence, then free-runs the slot grid that all SDRAM clients in the GPU decode:
- one-hot phase and bank-cycle strobes,
- a per-line round counter,
- the refresh window.

It is resynchronised to the video line by the horizontal-start pulse.

## Interface
Parameters:
- INIT_WAIT, default 7200: power-up idle clocks, 100 µs at 72 MHz.
- INIT_REFS, default 8: auto-refresh commands issued during init.
- LINE_ROUNDS, default 288: rounds per video line (288 × 16 clk = 64 µs).
- REF_START, default 256: first round of the refresh window.
- REF_ROUNDS, default 8: length of the refresh window, in rounds.
- MODE_REG, default 13'h0022: value for the mode-register load (CAS latency 2, burst 4).

Ports:
- clk, in, 1: master clock, 72 MHz.
- rst, in, 1: global reset; one clock; reset is asynchronous and active-low.
- line_start, in, 1: one-clock pulse at the start of each video line.
- init_done, out, 1: high once the power-up sequence has completed.
- init_vld, out, 1: an init command is valid this clock.
- init_cmd, out, 3: {RAS_n, CAS_n, WE_n} for the init command.
- init_addr, out, 13: address bus value during the init command.
- ram_ph, out, 4: one-hot clock phase within a slot.
- ram_cyc, out, 4: one-hot bank slot within a round.
- ram_ph_ctr, out, 9: round counter within the line.
- ram_ref, out, 1: refresh window active.

## Operation
Slot grid:
- ram_ph rotates 0001→0010→0100→1000→0001, one step per clock.
- ram_cyc advances one position each time ram_ph[3] is high. One slot is 4 clocks; one round is 16 clocks.
- ram_ph_ctr increments at the end of each round, i.e. when ram_cyc[3] and ram_ph[3] are both high.
- After LINE_ROUNDS-1, ram_ph_ctr wraps to 0.

Line resync:
- line_start is latched into a pending flag.
- At the next round end, ram_ph_ctr loads 0 instead of incrementing, and the flag clears.
- ram_ph and ram_cyc are never disturbed by a resync.
- If line_start coincides with a round end, that round end applies it.

Refresh window:
- ram_ref = init_done & (REF_START ≤ ram_ph_ctr < REF_START+REF_ROUNDS).
- ram_ref changes only at round boundaries.

Init FSM (states WAIT → PRE → REF → MRS → RUN):
- **WAIT:** a 13-bit counter counts INIT_WAIT clocks. Then go to PRE, aligned to the next ram_cyc[0]&ram_ph[0].
- **PRE:** one clock with init_vld=1, init_cmd=3'b010 (precharge), init_addr[10]=1. Next state REF.
- **REF:** on ram_cyc[0]&ram_ph[0] of each round, issue init_cmd=3'b001 (auto-refresh), init_vld=1. Issue INIT_REFS of them, one per round, then go to MRS.
- **MRS:** on the next ram_cyc[0]&ram_ph[0], issue init_cmd=3'b000 with init_addr=MODE_REG. Next state RUN.
- **RUN:** init_done=1 permanently; init_vld=0.

Before RUN:
- ram_ph and ram_cyc run normally; this is needed for the command alignment above.
- ram_ph_ctr is held at 0 and ram_ref=0.
- line_start is ignored.

ram_ph_ctr is 9-bit unsigned. LINE_ROUNDS ≤ 512 and REF_START+REF_ROUNDS ≤ LINE_ROUNDS are enforced by an elaboration-time check.

## Timing
- All outputs are registered.
- Reset values:
  - ram_ph=4'b0001, ram_cyc=4'b0001
  - ram_ph_ctr=0, ram_ref=0
  - init_done=0, init_vld=0
  - init_cmd=3'b111 (NOP), init_addr=0
  - FSM in WAIT, resync flag cleared
- Output relationships:
  - First clock after reset release: ram_ph=0010.
  - Every init command has init_vld high for exactly one clock, coincident with ram_cyc[0]&ram_ph[0]. Minimum spacing between init commands is 16 clocks (satisfies tRP/tRFC/tMRD at 72 MHz).
  - init_done rises on the clock after the MRS command.
  - ram_ph_ctr starts counting from 0 at the first round end after init_done.
  - ram_ref asserts on the clock where ram_ph_ctr becomes REF_START and deasserts on the clock where it leaves the window.
- Reset mid-operation: all state returns to reset values immediately (asynchronous), and the full init sequence reruns.

## Structure
- Shared package gpu_sdram_pkg, which holds:
  - SDRAM command encodings: NOP, PRE, REF, MRS, ACT, RD, WR.
  - Init FSM state enum.
  - Default timing constants (INIT_WAIT, LINE_ROUNDS).

  The GPU DMA sequencer and the SDRAM controller import the same package.
- One natural sub-module: gpu_sdram_init, containing the init FSM plus its wait and refresh counters. The grid and line counters stay in the top level.

## Test plan
1. Reset release:
   - init_cmd sequence: PRE at clock ≈7200 (aligned to ram_cyc[0]&ram_ph[0]), then 8 REF 16 clocks apart, then MRS with init_addr=13'h0022.
   - init_done=1 one clock after MRS.
   - ram_ph_ctr=0 throughout init.
2. Free-run after init with no line_start:
   - ram_ph_ctr counts 0..287 then wraps to 0, every 16 clocks.
   - ram_ref high exactly for rounds 256..263, i.e. 128 clocks.
3. line_start pulse mid-round at ram_ph_ctr=100:
   - At the next round end, ram_ph_ctr=0.
   - ram_ph/ram_cyc continue without a glitch.
4. line_start coincident with a round end (ram_cyc[3]&ram_ph[3]): ram_ph_ctr=0 on the next clock, not 1.
5. line_start during init: ignored. First post-init round counts 0→1 normally.
6. rst asserted during the REF state (after 3 refreshes):
   - Outputs return to reset values immediately.
   - After release the full sequence restarts with a fresh 7200-clock wait.
